// File: rtl/clock_divider_multi.sv
`default_nettype none
// ============================================================================
// Module   : clock_divider_multi
// Purpose  : Multi-channel programmable clock-enable generator and slow-clock
//            divider. Each channel counts 0..D and then wraps. On the wrap edge
//            it emits a one-cycle tick and toggles a 50%-duty slow clock, so
//            the tick period is D+1 cycles and the slow_clk period is
//            2*(D+1) cycles.
// Ports    : clk        - system clock, rising edge
//            rst        - synchronous active-high reset
//            enable     - per-channel run enable
//            div_load   - per-channel one-cycle divisor load request
//            div_in     - requested divisors, channel i at [i*CNT_W +: CNT_W]
//            tick       - per-channel terminal-count pulse (registered)
//            slow_clk   - per-channel square wave (registered)
//            div_active - divisor currently in use by each channel
// Revision : 1.0 - initial release
// ============================================================================
module clock_divider_multi #(
    parameter int CHANNELS    = 4,
    parameter int CNT_W       = 24,
    parameter int DEFAULT_DIV = 250000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       enable,
    input  logic [CHANNELS-1:0]       div_load,
    input  logic [CHANNELS*CNT_W-1:0] div_in,
    output logic [CHANNELS-1:0]       tick,
    output logic [CHANNELS-1:0]       slow_clk,
    output logic [CHANNELS*CNT_W-1:0] div_active
);

    localparam logic [CNT_W-1:0] c_default_div = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] c_one         = CNT_W'(1);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] r_div;
        logic [CNT_W-1:0] r_pend;
        logic             r_pend_v;
        logic             r_tick;
        logic             r_slow;
        logic [CNT_W-1:0] w_din;
        logic             w_tc;

        assign w_din = div_in[i*CNT_W +: CNT_W];
        assign w_tc  = (r_cnt == r_div);

        always_ff @(posedge clk) begin
            if (rst) begin
                r_cnt    <= '0;
                r_div    <= c_default_div;
                r_pend   <= '0;
                r_pend_v <= 1'b0;
                r_tick   <= 1'b0;
                r_slow   <= 1'b0;
            end else if (enable[i]) begin
                if (w_tc) begin
                    r_cnt    <= '0;
                    r_tick   <= 1'b1;
                    r_slow   <= ~r_slow;
                    r_pend_v <= 1'b0;
                    // A load arriving on the wrap edge is newer than any
                    // pending value, so it takes effect for the next period.
                    if (div_load[i]) begin
                        r_div <= w_din;
                    end else if (r_pend_v) begin
                        r_div <= r_pend;
                    end
                end else begin
                    r_cnt  <= r_cnt + c_one;
                    r_tick <= 1'b0;
                    // Mid-period loads are deferred so the running period
                    // always finishes with the divisor it started with.
                    if (div_load[i]) begin
                        r_pend   <= w_din;
                        r_pend_v <= 1'b1;
                    end
                end
            end else begin
                r_tick <= 1'b0;
                // While stopped there is no period to protect: apply the new
                // divisor at once and restart the count; slow_clk is kept.
                if (div_load[i]) begin
                    r_div    <= w_din;
                    r_cnt    <= '0;
                    r_pend_v <= 1'b0;
                end
            end
        end

        assign tick[i]                       = r_tick;
        assign slow_clk[i]                   = r_slow;
        assign div_active[i*CNT_W +: CNT_W]  = r_div;
    end

endmodule
`default_nettype wire

// File: tb/tb_clock_divider_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_clock_divider_multi
// Purpose  : Self-checking bench for clock_divider_multi with two channels,
//            8-bit counters and a default divisor of 3.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clock_divider_multi;

    localparam int CHANNELS    = 2;
    localparam int CNT_W       = 8;
    localparam int DEFAULT_DIV = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  enable = 2'b00;
    logic [1:0]  div_load = 2'b00;
    logic [15:0] div_in = 16'h0000;
    logic [1:0]  tick;
    logic [1:0]  slow_clk;
    logic [15:0] div_active;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    clock_divider_multi #(
        .CHANNELS    (CHANNELS),
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .div_load   (div_load),
        .div_in     (div_in),
        .tick       (tick),
        .slow_clk   (slow_clk),
        .div_active (div_active)
    );

    typedef struct {
        logic [1:0]  en;
        logic [1:0]  ld;
        logic [15:0] din;
        logic [1:0]  exp_tick;
        logic [1:0]  exp_slow;
        logic [15:0] exp_da;
    } vec_t;

    vec_t vecs [12];

    // Drive inputs on the falling edge, sample 1 time unit after rising edge.
    task automatic step(input logic [1:0] en_v, input logic [1:0] ld_v,
                        input logic [15:0] din_v, input logic rst_v);
        @(negedge clk);
        rst      = rst_v;
        enable   = en_v;
        div_load = ld_v;
        div_in   = din_v;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int cyc,
                       input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    task automatic do_reset();
        step(2'b00, 2'b00, 16'h0000, 1'b1);
        step(2'b00, 2'b00, 16'h0000, 1'b1);
        chk("reset_tick", 0, {14'd0, tick}, 16'h0000);
        chk("reset_slow", 0, {14'd0, slow_clk}, 16'h0000);
        chk("reset_div_active", 0, div_active, 16'h0303);
    endtask

    initial begin
        // Both channels run D=3; channel 0 gets div 1 loaded at cnt=1 (edge 2).
        vecs[0]  = '{2'b11, 2'b00, 16'h0000, 2'b00, 2'b00, 16'h0303};
        vecs[1]  = '{2'b11, 2'b01, 16'h0001, 2'b00, 2'b00, 16'h0303};
        vecs[2]  = '{2'b11, 2'b00, 16'h0000, 2'b00, 2'b00, 16'h0303};
        vecs[3]  = '{2'b11, 2'b00, 16'h0000, 2'b11, 2'b11, 16'h0301};
        vecs[4]  = '{2'b11, 2'b00, 16'h0000, 2'b00, 2'b11, 16'h0301};
        vecs[5]  = '{2'b11, 2'b00, 16'h0000, 2'b01, 2'b10, 16'h0301};
        vecs[6]  = '{2'b11, 2'b00, 16'h0000, 2'b00, 2'b10, 16'h0301};
        vecs[7]  = '{2'b11, 2'b00, 16'h0000, 2'b11, 2'b01, 16'h0301};
        vecs[8]  = '{2'b11, 2'b00, 16'h0000, 2'b00, 2'b01, 16'h0301};
        vecs[9]  = '{2'b11, 2'b00, 16'h0000, 2'b01, 2'b00, 16'h0301};
        vecs[10] = '{2'b11, 2'b00, 16'h0000, 2'b00, 2'b00, 16'h0301};
        vecs[11] = '{2'b11, 2'b00, 16'h0000, 2'b11, 2'b11, 16'h0301};

        // ---------------- table: default periods + enabled load ----------------
        do_reset();
        for (int k = 0; k < 12; k++) begin
            step(vecs[k].en, vecs[k].ld, vecs[k].din, 1'b0);
            chk("tbl_tick", k + 1, {14'd0, tick}, {14'd0, vecs[k].exp_tick});
            chk("tbl_slow", k + 1, {14'd0, slow_clk}, {14'd0, vecs[k].exp_slow});
            chk("tbl_div_active", k + 1, div_active, vecs[k].exp_da);
        end

        // ---------------- disabled load of D=0 on channel 1 ----------------
        do_reset();
        step(2'b01, 2'b10, 16'h0000, 1'b0);
        chk("dis_load_da", 1, div_active, 16'h0003);
        chk("dis_load_tick", 1, {14'd0, tick}, 16'h0000);
        for (int k = 2; k <= 9; k++) begin
            step(2'b11, 2'b00, 16'h0000, 1'b0);
            chk("d0_tick1", k, {15'd0, tick[1]}, 16'h0001);
            chk("d0_slow1", k, {15'd0, slow_clk[1]}, {15'd0, (k % 2 == 0)});
            chk("d0_tick0", k, {15'd0, tick[0]}, {15'd0, (k % 4 == 0)});
            chk("d0_slow0", k, {15'd0, slow_clk[0]}, {15'd0, (k >= 4 && k < 8)});
        end

        // ---------------- enable pause at cnt=2 with slow_clk=1 ----------------
        do_reset();
        for (int k = 1; k <= 6; k++) begin
            step(2'b01, 2'b00, 16'h0000, 1'b0);
            chk("pre_pause_tick", k, {15'd0, tick[0]}, {15'd0, (k == 4)});
        end
        for (int k = 7; k <= 11; k++) begin
            step(2'b00, 2'b00, 16'h0000, 1'b0);
            chk("pause_tick", k, {14'd0, tick}, 16'h0000);
            chk("pause_slow", k, {15'd0, slow_clk[0]}, 16'h0001);
        end
        step(2'b01, 2'b00, 16'h0000, 1'b0);
        chk("resume_tick_early", 12, {15'd0, tick[0]}, 16'h0000);
        step(2'b01, 2'b00, 16'h0000, 1'b0);
        chk("resume_tick", 13, {15'd0, tick[0]}, 16'h0001);
        chk("resume_slow", 13, {15'd0, slow_clk[0]}, 16'h0000);

        // ---------------- two loads before the wrap: last wins ----------------
        do_reset();
        step(2'b01, 2'b01, 16'h0007, 1'b0);
        step(2'b01, 2'b01, 16'h0005, 1'b0);
        chk("two_load_da_hold", 2, div_active, 16'h0303);
        step(2'b01, 2'b00, 16'h0000, 1'b0);
        step(2'b01, 2'b00, 16'h0000, 1'b0);
        chk("two_load_wrap_tick", 4, {15'd0, tick[0]}, 16'h0001);
        chk("two_load_da", 4, div_active, 16'h0305);
        for (int k = 5; k <= 16; k++) begin
            step(2'b01, 2'b00, 16'h0000, 1'b0);
            chk("two_load_tick", k, {15'd0, tick[0]}, {15'd0, (k == 10 || k == 16)});
        end
        chk("two_load_slow", 16, {15'd0, slow_clk[0]}, 16'h0001);

        // ---------------- reset mid-period with pending load ----------------
        step(2'b01, 2'b01, 16'h0002, 1'b0);
        chk("pend_before_rst_tick", 17, {15'd0, tick[0]}, 16'h0000);
        step(2'b01, 2'b00, 16'h0000, 1'b1);
        chk("midrst_tick", 18, {14'd0, tick}, 16'h0000);
        chk("midrst_slow", 18, {14'd0, slow_clk}, 16'h0000);
        chk("midrst_da", 18, div_active, 16'h0303);
        for (int k = 1; k <= 12; k++) begin
            // Load div 1 on the terminal-count edge 12: next period uses it.
            step(2'b01, (k == 12) ? 2'b01 : 2'b00, (k == 12) ? 16'h0001 : 16'h0000, 1'b0);
            chk("postrst_tick", k, {15'd0, tick[0]}, {15'd0, (k % 4 == 0)});
        end
        chk("tc_load_da", 12, div_active, 16'h0301);
        for (int k = 13; k <= 16; k++) begin
            step(2'b01, 2'b00, 16'h0000, 1'b0);
            chk("tc_load_tick", k, {15'd0, tick[0]}, {15'd0, (k % 2 == 0)});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
